// File: rtl/smpc_pkg.sv
// -----------------------------------------------------------------------------
// smpc_pkg
// Shared definitions for the SMPC peripheral port scanner:
//   - port pin bit positions (TH/TR select lines)
//   - OREG status / peripheral ID byte constants
//   - scanner state enum
//   - small helper that recognises a standard digital pad from its ID nibble
// -----------------------------------------------------------------------------
package smpc_pkg;

    localparam int PIN_TH = 6;
    localparam int PIN_TR = 5;

    localparam logic [7:0] PST_NONE = 8'hF0;   // port status: nothing connected
    localparam logic [7:0] PST_ONE  = 8'hF1;   // port status: one device
    localparam logic [7:0] ID_DPAD  = 8'h02;   // peripheral ID: digital pad

    // The sample step has no state of its own: it happens on the last
    // settle count, so a phase costs DRIVE + SETTLE_CYC cycles.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FIN    = 3'd4
    } smpc_state_e;

    // A standard pad answers the {TH,TR}=11 phase with 3'b100 in the low bits.
    function automatic logic pad_present(input logic [3:0] nib3);
        return (nib3[2:0] == 3'b100);
    endfunction

endpackage

// File: rtl/smpc_pad_phy.sv
// -----------------------------------------------------------------------------
// smpc_pad_phy
// One controller port: owns the TH/TR drive register and the four captured
// data nibbles (one per select phase).
//
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_drive         load i_sel ({TH,TR}) into the drive register
//   i_sel           select value to drive
//   i_release       return TH=TR=1 (wins over i_drive)
//   i_sample        capture i_data into nib[i_phase]
//   i_phase         phase index 0..3
//   i_data          port data pins [3:0]
//   o_pins          port drive; only TH/TR bits are ever non-zero
//   o_nib           captured nibbles, o_nib[p] = nib[p]
// -----------------------------------------------------------------------------
module smpc_pad_phy
    import smpc_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_drive,
    input  logic [1:0]      i_sel,
    input  logic            i_release,
    input  logic            i_sample,
    input  logic [1:0]      i_phase,
    input  logic [3:0]      i_data,
    output logic [6:0]      o_pins,
    output logic [3:0][3:0] o_nib
);

    logic [1:0]      r_sel;    // {TH,TR}
    logic [3:0][3:0] r_nib;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel <= 2'b11;
            r_nib <= '0;
        end else begin
            if (i_release) begin
                r_sel <= 2'b11;
            end else if (i_drive) begin
                r_sel <= i_sel;
            end
            if (i_sample) begin
                r_nib[i_phase] <= i_data;
            end
        end
    end

    always_comb begin
        o_pins         = '0;
        o_pins[PIN_TH] = r_sel[1];
        o_pins[PIN_TR] = r_sel[0];
    end

    assign o_nib = r_nib;

endmodule

// File: rtl/smpc_pad_scan.sv
// -----------------------------------------------------------------------------
// smpc_pad_scan
// Peripheral port scanner. On i_start it walks the enabled ports, driving the
// four {TH,TR} select phases on each, captures the data nibbles, and streams
// the decoded digital-pad bytes into OREG.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_ce                clock enable; sequencing advances only when high
//   i_start             scan request (sampled in IDLE only)
//   i_pen               port enable mask, bit0 = port 1, bit1 = port 2
//   i_abort             synchronous abort, honoured regardless of i_ce
//   o_busy              scan in progress
//   o_done              one-CE-cycle completion pulse
//   o_count             bytes written by the last completed scan
//   o_wr/o_waddr/o_wdata OREG write port
//   i_p1i, i_p2i        port pins: [3:0] data, [4] TL, [5] TR, [6] TH
//   o_p1o, o_p2o        port drive: [6] TH, [5] TR, [4:0] always 0
//   o_state             current scanner state (observability)
//
// OREG write port: o_wr is a strobe with no back-pressure. A byte is
// transferred on every CE cycle where o_wr is high; o_waddr/o_wdata are valid
// in that cycle and hold their value afterwards.
// -----------------------------------------------------------------------------
module smpc_pad_scan
    import smpc_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 8     // legal range 1..255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic        i_start,
    input  logic [1:0]  i_pen,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_count,
    output logic        o_wr,
    output logic [4:0]  o_waddr,
    output logic [7:0]  o_wdata,
    input  logic [6:0]  i_p1i,
    input  logic [6:0]  i_p2i,
    output logic [6:0]  o_p1o,
    output logic [6:0]  o_p2o,
    output smpc_state_e o_state
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    smpc_state_e r_state, w_state_nxt;

    logic       r_pen2;      // port 2 enabled for this scan
    logic       r_port;      // 0 = port 1, 1 = port 2
    logic [1:0] r_phase;
    logic [7:0] r_cnt;
    logic [1:0] r_bsel;      // byte within the current port's record
    logic [3:0] r_idx;       // OREG byte index, max 8
    logic       r_busy;
    logic       r_done;
    logic       r_wr;
    logic [4:0] r_waddr;
    logic [7:0] r_wdata;
    logic [3:0] r_count;

    logic            w_go;
    logic            w_drive;
    logic            w_sample;
    logic            w_emit;
    logic            w_fin;
    logic            w_drv_port;
    logic [1:0]      w_sel;
    logic            w_present;
    logic            w_last_byte;
    logic            w_more;
    logic            w_port_done;
    logic [7:0]      w_byte;
    logic [3:0][3:0] w_p1_nib;
    logic [3:0][3:0] w_p2_nib;
    logic [3:0][3:0] w_cur_nib;
    logic            w_unused_pins;

    assign w_unused_pins = ^{i_p1i[6:4], i_p2i[6:4]};

    assign w_cur_nib   = r_port ? w_p2_nib : w_p1_nib;
    assign w_present   = pad_present(w_cur_nib[3]);
    assign w_last_byte = w_present ? (r_bsel == 2'd3) : 1'b1;
    assign w_more      = (r_port == 1'b0) && r_pen2;
    assign w_port_done = w_sample && (r_phase == 2'd3);

    // The START edge itself performs the phase-0 drive of the first port, so
    // the select lines move one CE cycle after START. Later phases and the
    // second port go through the DRIVE state.
    assign w_drv_port = (r_state == ST_IDLE) ? ~i_pen[0] : r_port;
    assign w_sel      = (r_state == ST_IDLE) ? 2'b00 : r_phase;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_drive     = 1'b0;
        w_sample    = 1'b0;
        w_emit      = 1'b0;
        w_fin       = 1'b0;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else if (i_ce) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_go = 1'b1;
                        if (i_pen == 2'b00) begin
                            w_state_nxt = ST_FIN;
                        end else begin
                            w_drive     = 1'b1;
                            w_state_nxt = ST_SETTLE;
                        end
                    end
                end
                ST_DRIVE: begin
                    w_drive     = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        w_sample    = 1'b1;
                        w_state_nxt = (r_phase == 2'd3) ? ST_EMIT : ST_DRIVE;
                    end
                end
                ST_EMIT: begin
                    w_emit = 1'b1;
                    if (w_last_byte) begin
                        w_state_nxt = w_more ? ST_DRIVE : ST_FIN;
                    end
                end
                ST_FIN: begin
                    w_fin       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ byte encoder
    always_comb begin
        w_byte = PST_NONE;
        case (r_bsel)
            2'd0:    w_byte = w_present ? PST_ONE : PST_NONE;
            2'd1:    w_byte = ID_DPAD;
            2'd2:    w_byte = {w_cur_nib[0], w_cur_nib[1]};
            default: w_byte = {w_cur_nib[2], w_cur_nib[3][3], 3'b111};
        endcase
    end

    // --------------------------------------------------------- datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pen2  <= 1'b0;
            r_port  <= 1'b0;
            r_phase <= 2'd0;
            r_cnt   <= 8'd0;
            r_bsel  <= 2'd0;
            r_idx   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wr    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 8'd0;
            r_count <= 4'd0;
        end else if (i_abort) begin
            // Address/data/count keep their values; only the activity flags drop.
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_wr   <= 1'b0;
        end else if (i_ce) begin
            r_done <= w_fin;
            r_wr   <= w_emit;
            if (w_go) begin
                r_pen2  <= i_pen[1];
                r_port  <= w_drv_port;
                r_phase <= 2'd0;
                r_idx   <= 4'd0;
                r_busy  <= 1'b1;
            end
            if (w_drive) begin
                r_cnt <= SETTLE_LOAD;
            end else if ((r_state == ST_SETTLE) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_sample) begin
                r_phase <= r_phase + 2'd1;    // wraps to 0 after phase 3
                r_bsel  <= 2'd0;
            end
            if (w_emit) begin
                r_idx   <= r_idx + 4'd1;
                r_bsel  <= r_bsel + 2'd1;
                r_waddr <= {1'b0, r_idx};
                r_wdata <= w_byte;
                if (w_last_byte) begin
                    r_port <= 1'b1;           // only used if port 2 follows
                end
            end
            if (w_fin) begin
                r_busy  <= 1'b0;
                r_count <= r_idx;
            end
        end
    end

    // ------------------------------------------------------ port PHYs
    smpc_pad_phy u_phy1 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_drive   (w_drive && (w_drv_port == 1'b0)),
        .i_sel     (w_sel),
        .i_release (i_abort || (w_port_done && (r_port == 1'b0))),
        .i_sample  (w_sample && (r_port == 1'b0)),
        .i_phase   (r_phase),
        .i_data    (i_p1i[3:0]),
        .o_pins    (o_p1o),
        .o_nib     (w_p1_nib)
    );

    smpc_pad_phy u_phy2 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_drive   (w_drive && (w_drv_port == 1'b1)),
        .i_sel     (w_sel),
        .i_release (i_abort || (w_port_done && (r_port == 1'b1))),
        .i_sample  (w_sample && (r_port == 1'b1)),
        .i_phase   (r_phase),
        .i_data    (i_p2i[3:0]),
        .o_pins    (o_p2o),
        .o_nib     (w_p2_nib)
    );

    // ------------------------------------------------------- outputs
    // Strobes are gated by CE so a held register never repeats a pulse.
    assign o_wr    = r_wr & i_ce;
    assign o_done  = r_done & i_ce;
    assign o_busy  = r_busy;
    assign o_count = r_count;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_state = r_state;

endmodule

// File: tb/tb_smpc_pad_scan.sv
module tb_smpc_pad_scan;
  import smpc_pkg::*;

  localparam int W      = 13;   // {waddr[4:0], wdata[7:0]}
  localparam int SETTLE = 8;

  logic        clk;
  logic        rst_n;
  logic        i_ce;
  logic        i_start;
  logic [1:0]  i_pen;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_count;
  logic        o_wr;
  logic [4:0]  o_waddr;
  logic [7:0]  o_wdata;
  logic [6:0]  i_p1i;
  logic [6:0]  i_p2i;
  logic [6:0]  o_p1o;
  logic [6:0]  o_p2o;
  smpc_state_e o_state;

  logic [W-1:0] exp_q[$];
  logic [3:0]   p1_tab [4];
  logic [3:0]   p2_tab [4];
  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int ce_div   = 1;
  int ce_ph    = 0;
  int saved_done;

  smpc_pad_scan #(.SETTLE_CYC(SETTLE)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_ce    (i_ce),
    .i_start (i_start),
    .i_pen   (i_pen),
    .i_abort (i_abort),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_count (o_count),
    .o_wr    (o_wr),
    .o_waddr (o_waddr),
    .o_wdata (o_wdata),
    .i_p1i   (i_p1i),
    .i_p2i   (i_p2i),
    .o_p1o   (o_p1o),
    .o_p2o   (o_p2o),
    .o_state (o_state)
  );

  // ---------------------------------------------------- clock / reset / CE
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    i_ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ce_ph = (ce_ph + 1) % ce_div;
      i_ce  = (ce_ph == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pad model: the data nibble follows the {TH,TR} select being driven.
  always_comb begin
    i_p1i = {3'b111, p1_tab[o_p1o[6:5]]};
    i_p2i = {3'b111, p2_tab[o_p2o[6:5]]};
  end

  // ---------------------------------------------------- helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_ce();
    do @(negedge clk); while (i_ce !== 1'b1);
  endtask

  task automatic start_scan(input logic [1:0] pen);
    @(posedge clk);
    #1;
    i_pen   = pen;
    i_start = 1'b1;
    do @(posedge clk); while (i_ce !== 1'b1);
    #1;
    i_start = 1'b0;
  endtask

  task automatic run_scan(input logic [1:0] pen, input int exp_k, input logic [3:0] exp_count,
                          input logic [6:0] p1o_k1, input logic [6:0] p2o_k1,
                          input logic [6:0] p1o_k10, input logic [6:0] p2o_k10,
                          input int again_k);
    int got_k;
    int done_before;
    done_before = done_cnt;
    got_k = -1;
    start_scan(pen);
    for (int k = 1; k <= 400; k++) begin
      wait_ce();
      if (k == 1) begin
        check("busy_after_start", o_busy, 1'b1);
        check("p1o_first_cycle", o_p1o, p1o_k1);
        check("p2o_first_cycle", o_p2o, p2o_k1);
      end
      if (k == 10) begin
        check("p1o_phase1", o_p1o, p1o_k10);
        check("p2o_phase1", o_p2o, p2o_k10);
      end
      if (k == again_k) begin
        i_start = 1'b1;
        i_pen   = 2'b11;
      end
      if (k == again_k + 1) begin
        i_start = 1'b0;
        i_pen   = pen;
      end
      if (o_done === 1'b1) begin
        got_k = k;
        break;
      end
    end
    check("done_latency", got_k, exp_k);
    check("busy_at_done", o_busy, 1'b0);
    check("count", o_count, exp_count);
    check("writes_drained", exp_q.size(), 0);
    repeat (20) wait_ce();
    check("done_pulses", done_cnt - done_before, 1);
    check("p1o_after", o_p1o, 7'h60);
    check("p2o_after", o_p2o, 7'h60);
  endtask

  // ---------------------------------------------------- scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (o_wr === 1'b1) begin
          n_vec++;
          assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL wr_unexpected: observed addr %0d data 'h%0h, expected no write", o_waddr, o_wdata);
          end
          if (exp_q.size() > 0) check("oreg_write", {o_waddr, o_wdata}, exp_q.pop_front());
        end
        if (o_done === 1'b1) done_cnt++;
        if (i_ce === 1'b0) check("ce_gate_wr_done", {o_wr, o_done}, 2'b00);
      end
    end
  end

  // ---------------------------------------------------- directed sequence
  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_pen   = 2'b00;
    i_abort = 1'b0;
    p1_tab  = '{4'h0, 4'h0, 4'h0, 4'h0};
    p2_tab  = '{4'h0, 4'h0, 4'h0, 4'h0};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p1o", o_p1o, 7'h60);
    check("rst_p2o", o_p2o, 7'h60);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_wr", o_wr, 1'b0);
    check("rst_waddr", o_waddr, 5'd0);
    check("rst_wdata", o_wdata, 8'd0);
    check("rst_count", o_count, 4'd0);
    check("rst_state", o_state, ST_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle CE stream
    repeat (10) wait_ce();
    check("idle_p1o", o_p1o, 7'h60);
    check("idle_p2o", o_p2o, 7'h60);
    check("idle_busy", o_busy, 1'b0);

    // Port 1 only, pad present: nibbles A,5,C,4
    p1_tab = '{4'hA, 4'h5, 4'hC, 4'h4};
    push(5'd0, 8'hF1); push(5'd1, 8'h02); push(5'd2, 8'hA5); push(5'd3, 8'hC7);
    run_scan(2'b01, 41, 4'd4, 7'h00, 7'h60, 7'h20, 7'h60, 0);

    // Both ports: port 1 absent (nib3=7), port 2 present F,F,F,C
    p1_tab = '{4'h1, 4'h2, 4'h3, 4'h7};
    p2_tab = '{4'hF, 4'hF, 4'hF, 4'hC};
    push(5'd0, 8'hF0);
    push(5'd1, 8'hF1); push(5'd2, 8'h02); push(5'd3, 8'hFF); push(5'd4, 8'hFF);
    run_scan(2'b11, 78, 4'd5, 7'h00, 7'h60, 7'h20, 7'h60, 0);

    // Abort during port-2 settle
    p1_tab = '{4'hA, 4'h5, 4'hC, 4'h4};
    push(5'd0, 8'hF1); push(5'd1, 8'h02); push(5'd2, 8'hA5); push(5'd3, 8'hC7);
    saved_done = done_cnt;
    start_scan(2'b11);
    repeat (45) wait_ce();
    check("abort_pre_p2o", o_p2o, 7'h00);
    check("abort_pre_state", o_state, ST_SETTLE);
    check("abort_pre_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    i_abort = 1'b1;
    @(posedge clk);
    #1;
    i_abort = 1'b0;
    @(negedge clk);
    check("abort_state", o_state, ST_IDLE);
    check("abort_p2o", o_p2o, 7'h60);
    check("abort_p1o", o_p1o, 7'h60);
    check("abort_busy", o_busy, 1'b0);
    check("abort_wr", o_wr, 1'b0);
    repeat (100) wait_ce();
    check("abort_no_done", done_cnt - saved_done, 0);
    check("abort_count_kept", o_count, 4'd5);

    // START together with ABORT in IDLE: no scan
    @(posedge clk);
    #1;
    i_pen   = 2'b01;
    i_start = 1'b1;
    i_abort = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", o_busy, 1'b0);
    check("abort_start_state", o_state, ST_IDLE);
    repeat (60) wait_ce();
    check("abort_start_p1o", o_p1o, 7'h60);
    check("abort_start_no_done", done_cnt - saved_done, 0);

    // Normal scan after abort: port 2 only
    push(5'd0, 8'hF1); push(5'd1, 8'h02); push(5'd2, 8'hFF); push(5'd3, 8'hFF);
    run_scan(2'b10, 41, 4'd4, 7'h60, 7'h00, 7'h60, 7'h20, 0);

    // No ports enabled
    run_scan(2'b00, 2, 4'd0, 7'h60, 7'h60, 7'h60, 7'h60, 0);

    // CE 1-in-3, second START while busy is ignored
    ce_div = 3;
    push(5'd0, 8'hF1); push(5'd1, 8'h02); push(5'd2, 8'hA5); push(5'd3, 8'hC7);
    run_scan(2'b01, 41, 4'd4, 7'h00, 7'h60, 7'h20, 7'h60, 20);
    ce_div = 1;
    repeat (5) wait_ce();

    // Asynchronous reset mid-scan
    saved_done = done_cnt;
    start_scan(2'b01);
    repeat (10) wait_ce();
    check("prereset_p1o", o_p1o, 7'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_p1o", o_p1o, 7'h60);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_state", o_state, ST_IDLE);
    check("midrst_count", o_count, 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) wait_ce();
    check("midrst_no_done", done_cnt - saved_done, 0);
    check("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
